// File: rtl/router_fsm_if.sv
// Router FSM handshake bundle: source byte stream, FIFO status flags,
// register-block status and the FSM's control outputs.
// master = environment side (source, FIFOs, register block), slave = the FSM.
interface router_fsm_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       write_enb_reg;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       busy;
   logic       wait_timeout;

   modport master (
      output pkt_valid, data_in, fifo_full,
             fifo_empty_0, fifo_empty_1, fifo_empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2,
             parity_done, low_pkt_valid,
      input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, busy, wait_timeout
   );

   modport slave (
      input  pkt_valid, data_in, fifo_full,
             fifo_empty_0, fifo_empty_1, fifo_empty_2,
             soft_reset_0, soft_reset_1, soft_reset_2,
             parity_done, low_pkt_valid,
      output write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
             full_state, rst_int_reg, busy, wait_timeout
   );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router. Moore machine, 8 binary-encoded states;
// every output decodes from registered state only.
// Optional feature macro ROUTER_FSM_WAIT_TIMEOUT_EN: bounds the time spent in
// WAIT_TILL_EMPTY to WAIT_TIMEOUT cycles and flags the give-up with a
// one-cycle wait_timeout pulse. Without it the FSM waits indefinitely.
module router_fsm #(
   parameter int WAIT_TIMEOUT = 1000,
   parameter int TO_W         = 16
) (
   input logic         clock,
   input logic         reset,
   router_fsm_if.slave bus
);
   localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] LOAD_DATA          = 3'd2;
   localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
   localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
   localparam logic [2:0] LOAD_PARITY        = 3'd5;
   localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
   localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

   // An empty block here marks an impossible timeout/counter-width pairing.
   if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT >= (2 ** TO_W)) begin : g_bad_wait_timeout_config
   end

   logic [2:0] state_q;
   logic [2:0] state_d;
   logic [1:0] addr_q;
   logic [3:0] emptyVec;
   logic [3:0] softVec;
   logic       emptyHdr;
   logic       emptyAddr;
   logic       softHit;
   logic       hdrValid;
   logic       timeoutHit;

   // Index 3 is the invalid address; padding with 0 keeps lookups in range.
   assign emptyVec  = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign softVec   = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
   assign emptyHdr  = emptyVec[bus.data_in];
   assign emptyAddr = emptyVec[addr_q];
   assign softHit   = (state_q != DECODE_ADDRESS) && softVec[addr_q];
   assign hdrValid  = bus.pkt_valid && (bus.data_in != 2'b11);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
   localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(WAIT_TIMEOUT - 1);

   logic [TO_W-1:0] waitCnt_q;
   logic            wait_timeout_q;

   assign timeoutHit = (state_q == WAIT_TILL_EMPTY) && (waitCnt_q == WAIT_LAST);

   // Count cycles spent in WAIT_TILL_EMPTY; zero everywhere else so entry starts at 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         waitCnt_q <= '0;
      end else if (state_q == WAIT_TILL_EMPTY) begin
         waitCnt_q <= waitCnt_q + 1'b1;
      end else begin
         waitCnt_q <= '0;
      end
   end

   // Pulse only when the timeout actually takes the exit (empty and soft reset win).
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_timeout_q <= 1'b0;
      end else begin
         wait_timeout_q <= timeoutHit && !emptyAddr && !softHit;
      end
   end

   assign bus.wait_timeout = wait_timeout_q;
`else
   assign timeoutHit       = 1'b0;
   assign bus.wait_timeout = 1'b0;
`endif

   // Next-state logic: soft reset on the active port overrides the transition table.
   always_comb begin
      state_d = state_q;
      if (softHit) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (hdrValid) state_d = emptyHdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)        state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
               if (emptyAddr)       state_d = LOAD_FIRST_DATA;
               else if (timeoutHit) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= DECODE_ADDRESS;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the destination from a valid header; invalid address 3 leaves it untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= 2'b00;
      end else if ((state_q == DECODE_ADDRESS) && hdrValid) begin
         addr_q <= bus.data_in;
      end
   end

   assign bus.detect_add    = (state_q == DECODE_ADDRESS);
   assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign bus.ld_state      = (state_q == LOAD_DATA);
   assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
   assign bus.full_state    = (state_q == FIFO_FULL_STATE);
   assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                              (state_q == LOAD_PARITY);
   assign bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios followed by a
// long randomized phase, all checked cycle by cycle against a name-based
// behavioural model of the router controller. Built with or without
// ROUTER_FSM_WAIT_TIMEOUT_EN; the model follows the same macro.
module tb_router_fsm;
   localparam int WAIT_TIMEOUT = 8;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset;

   router_fsm_if bus ();

   router_fsm #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .TO_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int    vecCount  = 0;
   int    missCount = 0;
   int    writes, busyCnt, fullCnt, pulseCnt;

   // Reference model: phase name, destination port, cycles waited, pulse flag.
   string      mState = "DA";
   logic [1:0] mAddr  = 2'd0;
   int         mWait  = 0;
   logic       mPulse = 1'b0;

   // Output order: write_enb, detect_add, lfd, ld, laf, full, rst_int, busy, wait_timeout.
   function automatic logic [8:0] expectedVec();
      logic we;
      logic bz;
      we = (mState == "LD") || (mState == "LAF") || (mState == "LP");
      bz = !((mState == "DA") || (mState == "LD"));
      return {we, mState == "DA", mState == "LFD", mState == "LD", mState == "LAF",
              mState == "FFS", mState == "CPE", bz, mPulse};
   endfunction

   function automatic logic [8:0] observedVec();
      return {bus.write_enb_reg, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.rst_int_reg, bus.busy, bus.wait_timeout};
   endfunction

   // Advance the model by one clock using the inputs present at the edge.
   task automatic modelStep();
      logic [3:0] emp;
      logic [3:0] sr;
      logic       pulse;
      logic       hdr;
      string      nxt;
      emp   = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
      sr    = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      pulse = 1'b0;
      if (reset) begin
         mState = "DA";
         mAddr  = 2'd0;
         mWait  = 0;
      end else begin
         hdr = bus.pkt_valid && (bus.data_in != 2'b11);
         nxt = mState;
         if (mState != "DA" && sr[mAddr]) nxt = "DA";
         else if (mState == "DA") begin
            if (hdr) nxt = emp[bus.data_in] ? "LFD" : "WTE";
         end
         else if (mState == "LFD") nxt = "LD";
         else if (mState == "LD") begin
            if (bus.fifo_full)       nxt = "FFS";
            else if (!bus.pkt_valid) nxt = "LP";
         end
         else if (mState == "FFS") begin
            if (!bus.fifo_full) nxt = "LAF";
         end
         else if (mState == "LAF") begin
            if (bus.parity_done)        nxt = "DA";
            else if (bus.low_pkt_valid) nxt = "LP";
            else                        nxt = "LD";
         end
         else if (mState == "LP") nxt = "CPE";
         else if (mState == "CPE") nxt = bus.fifo_full ? "FFS" : "DA";
         else if (mState == "WTE") begin
            if (emp[mAddr]) nxt = "LFD";
            else if (TIMEOUT_ON && mWait == WAIT_TIMEOUT - 1) begin
               nxt   = "DA";
               pulse = 1'b1;
            end
         end
         if (mState == "DA" && hdr) mAddr = bus.data_in;
         mWait  = (mState == "WTE") ? mWait + 1 : 0;
         mState = nxt;
      end
      mPulse = pulse;
   endtask

   task automatic checkOutput(input string tag);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = observedVec();
      exp = expectedVec();
      vecCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("FAIL %s: model=%s observed=%b expected=%b", tag, mState, obs, exp);
      end
   endtask

   task automatic checkValue(input string tag, input int obs, input int exp);
      vecCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model and compare all outputs.
   task automatic applyStimulus(input logic rst, input logic pv, input logic [1:0] d,
                                input logic full, input logic [2:0] emp, input logic [2:0] sr,
                                input logic pd, input logic lpv, input string tag);
      reset             = rst;
      bus.pkt_valid     = pv;
      bus.data_in       = d;
      bus.fifo_full     = full;
      bus.fifo_empty_0  = emp[0];
      bus.fifo_empty_1  = emp[1];
      bus.fifo_empty_2  = emp[2];
      bus.soft_reset_0  = sr[0];
      bus.soft_reset_1  = sr[1];
      bus.soft_reset_2  = sr[2];
      bus.parity_done   = pd;
      bus.low_pkt_valid = lpv;
      @(posedge clock);
      modelStep();
      #1;
      checkOutput(tag);
      writes   += int'(bus.write_enb_reg);
      busyCnt  += int'(bus.busy);
      fullCnt  += int'(bus.full_state);
      pulseCnt += int'(bus.wait_timeout);
   endtask

   task automatic clearTally();
      writes   = 0;
      busyCnt  = 0;
      fullCnt  = 0;
      pulseCnt = 0;
   endtask

   initial begin
      clearTally();

      $display("[TB] reset");
      repeat (2) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, "reset");
      checkValue("reset_outputs", int'(observedVec()), int'(9'b010000000));
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, "idle");

      $display("[TB] plain packet to port 1");
      clearTally();
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, "t2_header");
      repeat (17) applyStimulus(1'b0, 1'b1, 2'($urandom), 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, "t2_payload");
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, "t2_tail");
      checkValue("t2_write_cycles", writes, 18);
      checkValue("t2_busy_cycles", busyCnt, 3);

      $display("[TB] fifo full mid packet");
      clearTally();
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, "t3_header");
      repeat (5) applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, "t3_payload");
      repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, "t3_full");
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, "t3_laf");
      checkValue("t3_laf_state", int'(bus.laf_state), 1);
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, "t3_back_to_ld");
      checkValue("t3_full_cycles", fullCnt, 3);
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, "t3_tail");

      $display("[TB] wait till empty on port 2");
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, "t4_header");
      checkValue("t4_busy_in_wte", int'(bus.busy), 1);
      repeat (3) applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, "t4_wait");
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t4_empty");
      checkValue("t4_lfd_after_empty", int'(bus.lfd_state), 1);
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t4_payload");
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t4_tail");

      $display("[TB] invalid address header");
      applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t5_addr3");
      checkValue("t5_no_write", int'(bus.write_enb_reg), 0);
      checkValue("t5_stay_da", int'(bus.detect_add), 1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t5_idle");

      $display("[TB] soft reset");
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t6_header0");
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t6_lfd0");
      applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, "t6_soft_hit");
      checkValue("t6_soft_to_da", int'(bus.detect_add), 1);
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t6_header1");
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t6_lfd1");
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, "t6_soft_other");
      checkValue("t6_soft_ignored", int'(bus.ld_state), 1);
      repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, "t6_tail");

      $display("[TB] empty stuck low in wait state");
      clearTally();
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, "t7_header");
      repeat (7) applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, "t7_wait");
      repeat (5) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, "t7_after");
      checkValue("t7_timeout_pulses", pulseCnt, int'(TIMEOUT_ON));
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, "t7_escape");
      checkValue("t7_in_da", int'(bus.detect_add), 1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 63) == 0,
                       $urandom_range(0, 3) != 0,
                       2'($urandom),
                       $urandom_range(0, 3) == 0,
                       3'($urandom),
                       {$urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
                        $urandom_range(0, 31) == 0},
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0,
                       "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
